// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds FSM states, funct3 encodings and the latched access-control payload.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    // Control fields captured when a request is accepted
    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
    } lsu_ctl_t;

    // Access size in bytes from the low two funct3 bits
    function automatic int unsigned access_bytes(input logic [1:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Valid/ready data bus between the load/store unit and memory.
// One request per handshake, one response pulse per accepted request.
interface lsu_if #(
    parameter int unsigned XLEN = 32
);
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [XLEN-1:0]   bus_addr;
    logic [XLEN/8-1:0] bus_wstrb;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_rsp_valid;
    logic [XLEN-1:0]   bus_rdata;
    logic              bus_rsp_err;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ready, bus_rsp_valid, bus_rdata, bus_rsp_err
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ready, bus_rsp_valid, bus_rdata, bus_rsp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/replication and load lane select/extension.
// Store and load paths have independent size/offset controls.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]                st_size,
    input  logic [$clog2(XLEN/8)-1:0] st_offset,
    input  logic [XLEN-1:0]           st_data,
    output logic [XLEN/8-1:0]         wstrb,
    output logic [XLEN-1:0]           wdata,
    input  logic [2:0]                ld_funct3,
    input  logic [$clog2(XLEN/8)-1:0] ld_offset,
    input  logic [XLEN-1:0]           rdata,
    output logic [XLEN-1:0]           ld_data
);
    localparam int unsigned NB = XLEN / 8;

    int unsigned     st_bytes;
    int unsigned     ld_bytes;
    logic [XLEN-1:0] shifted;
    logic            sign;
    logic            ext;

    // Strobe covers the accessed bytes; every lane carries the low bytes of st_data
    always_comb begin
        st_bytes = access_bytes(st_size);
        wstrb    = '0;
        wdata    = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            wstrb[i]         = (i >= 32'(st_offset)) && (i < 32'(st_offset) + st_bytes);
            wdata[8*i +: 8]  = st_data[8*(i % st_bytes) +: 8];
        end
    end

    // Shift the addressed lane down, then sign- or zero-extend from the access size
    always_comb begin
        ld_bytes = access_bytes(ld_funct3[1:0]);
        shifted  = rdata >> {ld_offset, 3'b000};
        case (ld_funct3[1:0])
            2'd0:    sign = shifted[7];
            2'd1:    sign = shifted[15];
            2'd2:    sign = shifted[31];
            default: sign = shifted[XLEN-1];
        endcase
        ext     = sign & ~ld_funct3[2];
        ld_data = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            ld_data[i] = (i < 8 * ld_bytes) ? shifted[i] : ext;
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs MEM-stage accesses over a valid/ready bus with variable latency,
// stalling the pipeline while an access is outstanding.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_load,
    input  logic            mem_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic            stall,
    output logic [XLEN-1:0] load_data,
    output logic            load_valid,
    output logic            misaligned,
    output logic            fault,
    lsu_if.master           bus
);
    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);

    state_t state, state_next;

    logic            req_c, both_c, illegal_c, unalign_c;
    logic            chk_fault_c, chk_mis_c, accept_c;
    logic [OFFW-1:0] offset_c;
    logic [NB-1:0]   st_wstrb_c;
    logic [XLEN-1:0] st_wdata_c;
    logic [XLEN-1:0] ld_data_c;
    logic            bus_valid_c;

    logic [XLEN-1:0] addr_q;
    logic [NB-1:0]   wstrb_q;
    logic [XLEN-1:0] wdata_q;
    lsu_ctl_t        ctl_q;
    logic [OFFW-1:0] off_q;
    logic [XLEN-1:0] load_data_q;
    logic            load_valid_q;
    logic            fault_q;

    // Request qualification; gated by reset so nothing is reported while held in reset
    always_comb begin
        req_c       = (mem_load | mem_store) & reset;
        both_c      = mem_load & mem_store;
        illegal_c   = (funct3 == 3'b111) ||
                      ((XLEN == 32) && ((funct3 == LSU_D) || (funct3 == LSU_WU)));
        offset_c    = address[OFFW-1:0];
        unalign_c   = (offset_c & OFFW'(access_bytes(funct3[1:0]) - 32'd1)) != '0;
        chk_fault_c = req_c & (both_c | illegal_c);
        chk_mis_c   = req_c & ~both_c & ~illegal_c & unalign_c;
        accept_c    = req_c & ~both_c & ~illegal_c & ~unalign_c;
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_size   (funct3[1:0]),
        .st_offset (offset_c),
        .st_data   (store_data),
        .wstrb     (st_wstrb_c),
        .wdata     (st_wdata_c),
        .ld_funct3 (ctl_q.funct3),
        .ld_offset (off_q),
        .rdata     (bus.bus_rdata),
        .ld_data   (ld_data_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept_c)          state_next = ST_REQ;
            ST_REQ:  if (bus.bus_ready)     state_next = ST_RSP;
            ST_RSP:  if (bus.bus_rsp_valid) state_next = ST_DONE;
            ST_DONE:                        state_next = ST_IDLE;
            default:                        state_next = ST_IDLE;
        endcase
    end

    // Check failures report combinationally in IDLE; bus errors arrive registered in DONE
    always_comb begin
        stall       = 1'b0;
        misaligned  = 1'b0;
        fault       = fault_q;
        bus_valid_c = 1'b0;
        case (state)
            ST_IDLE: begin
                stall      = accept_c;
                misaligned = chk_mis_c;
                fault      = fault_q | chk_fault_c;
            end
            ST_REQ: begin
                stall       = 1'b1;
                bus_valid_c = 1'b1;
            end
            ST_RSP:  stall = 1'b1;
            default: ;
        endcase
    end

    // Request fields latched on accept; result registers live for the DONE cycle only
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            ctl_q        <= '0;
            off_q        <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            if ((state == ST_IDLE) && accept_c) begin
                addr_q       <= {address[XLEN-1:OFFW], {OFFW{1'b0}}};
                wstrb_q      <= mem_store ? st_wstrb_c : '0;
                wdata_q      <= mem_store ? st_wdata_c : '0;
                ctl_q.we     <= mem_store;
                ctl_q.funct3 <= funct3;
                off_q        <= offset_c;
            end
            if ((state == ST_RSP) && bus.bus_rsp_valid) begin
                load_valid_q <= ~ctl_q.we & ~bus.bus_rsp_err;
                fault_q      <= bus.bus_rsp_err;
                load_data_q  <= (ctl_q.we | bus.bus_rsp_err) ? '0 : ld_data_c;
            end
        end
    end

    assign bus.bus_valid = bus_valid_c;
    assign bus.bus_we    = ctl_q.we;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wstrb = wstrb_q;
    assign bus.bus_wdata = wdata_q;

    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu (XLEN=32) with a bus responder and an expected-result queue.
module tb_lsu;

    typedef struct {
        logic [31:0] data;
        logic        lv;
        logic        flt;
        int          stalls;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_load = 1'b0;
    logic        mem_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] address = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        fault;

    int n_assert = 0;
    int n_fail   = 0;
    exp_t sb[$];

    lsu_if #(.XLEN(32)) bus_if ();

    lsu #(.XLEN(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .funct3     (funct3),
        .address    (address),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misaligned (misaligned),
        .fault      (fault),
        .bus        (bus_if)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] data, input logic lv, input logic flt,
                                input int stalls, input logic [31:0] addr, input logic we,
                                input logic [3:0] wstrb, input logic [31:0] wdata);
        exp_t e;
        e.data = data; e.lv = lv; e.flt = flt; e.stalls = stalls;
        e.addr = addr; e.we = we; e.wstrb = wstrb; e.wdata = wdata;
        return e;
    endfunction

    // Drives one accepted access and plays the bus slave with the given wait states
    task automatic run_access(input string tag, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int ready_wait, input int rsp_wait, input logic err,
                              input exp_t e);
        exp_t got;
        int   cyc, stall_n, rdy_cnt, rsp_cnt, acc_n;
        bit   accepted, responded, done, lv_early, v_seen, acc_now, rsp_now;
        sb.push_back(e);
        @(posedge clock); #1;
        mem_load = ld; mem_store = st; funct3 = f3; address = addr; store_data = sdata;
        cyc = 0; stall_n = 0; rdy_cnt = 0; rsp_cnt = 0; acc_n = 0;
        accepted = 0; responded = 0; done = 0; lv_early = 0;
        while (!done && cyc < 50) begin
            bus_if.bus_ready     = (rdy_cnt >= ready_wait);
            rsp_now              = accepted && !responded && (rsp_cnt == rsp_wait);
            bus_if.bus_rsp_valid = rsp_now;
            bus_if.bus_rdata     = rsp_now ? rdata : 32'h5A5A_0F0F;
            bus_if.bus_rsp_err   = rsp_now && err;
            @(negedge clock);
            v_seen  = bus_if.bus_valid;
            acc_now = bus_if.bus_valid && bus_if.bus_ready;
            if (stall) stall_n++;
            if (stall && load_valid) lv_early = 1;
            if (acc_now) begin
                acc_n++;
                check({tag, " bus_addr"},  64'(bus_if.bus_addr),  64'(sb[0].addr));
                check({tag, " bus_we"},    64'(bus_if.bus_we),    64'(sb[0].we));
                check({tag, " bus_wstrb"}, 64'(bus_if.bus_wstrb), 64'(sb[0].wstrb));
                if (sb[0].we) check({tag, " bus_wdata"}, 64'(bus_if.bus_wdata), 64'(sb[0].wdata));
            end
            if (cyc > 0 && !stall) begin
                got = sb.pop_front();
                check({tag, " stall_cycles"}, 64'(stall_n),    64'(got.stalls));
                check({tag, " load_valid"},   64'(load_valid), 64'(got.lv));
                check({tag, " fault"},        64'(fault),      64'(got.flt));
                check({tag, " load_data"},    64'(load_data),  64'(got.data));
                done = 1;
            end
            @(posedge clock); #1;
            if (v_seen && !acc_now) rdy_cnt++;
            if (rsp_now) responded = 1;
            else if (accepted && !responded) rsp_cnt++;
            if (acc_now) accepted = 1;
            cyc++;
        end
        mem_load = 1'b0; mem_store = 1'b0;
        bus_if.bus_ready = 1'b0; bus_if.bus_rsp_valid = 1'b0; bus_if.bus_rsp_err = 1'b0;
        if (!done) begin
            check({tag, " completion_timeout"}, 64'(0), 64'(1));
            void'(sb.pop_front());
        end
        check({tag, " bus_requests"}, 64'(acc_n), 64'(1));
        check({tag, " no_early_load_valid"}, 64'(lv_early), 64'(0));
        @(negedge clock);
        check({tag, " load_valid_pulse_end"}, 64'(load_valid), 64'(0));
    endtask

    // Drives an access that must be rejected in its first cycle with no bus traffic
    task automatic run_reject(input string tag, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic exp_mis, input logic exp_flt);
        @(posedge clock); #1;
        mem_load = ld; mem_store = st; funct3 = f3; address = addr; store_data = 32'h1111_2222;
        bus_if.bus_ready = 1'b1;
        @(negedge clock);
        check({tag, " misaligned"}, 64'(misaligned), 64'(exp_mis));
        check({tag, " fault"},      64'(fault),      64'(exp_flt));
        check({tag, " stall"},      64'(stall),      64'(0));
        check({tag, " bus_valid"},  64'(bus_if.bus_valid), 64'(0));
        @(posedge clock); #1;
        mem_load = 1'b0; mem_store = 1'b0; bus_if.bus_ready = 1'b0;
        @(negedge clock);
        check({tag, " bus_valid_after"}, 64'(bus_if.bus_valid), 64'(0));
        check({tag, " pulse_end"}, 64'(misaligned | fault), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus_if.bus_ready = 1'b0; bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rdata = 32'h0; bus_if.bus_rsp_err = 1'b0;
        // Request held during reset must not show up on any output
        mem_load = 1'b1; funct3 = 3'b010; address = 32'h100;
        repeat (2) @(negedge clock);
        check("reset stall",      64'(stall),            64'(0));
        check("reset bus_valid",  64'(bus_if.bus_valid), 64'(0));
        check("reset load_valid", 64'(load_valid),       64'(0));
        check("reset fault",      64'(fault | misaligned), 64'(0));
        check("reset load_data",  64'(load_data),        64'(0));
        mem_load = 1'b0;
        @(negedge clock); reset = 1'b1;

        run_access("LW",  1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0,
                   mk(32'hDEAD_BEEF, 1, 0, 3, 32'h100, 0, 4'b0000, 32'h0));
        run_access("SB",  0, 1, 3'b000, 32'h203, 32'h0000_00A5, 32'h0, 0, 0, 0,
                   mk(32'h0, 0, 0, 3, 32'h200, 1, 4'b1000, 32'hA5A5_A5A5));
        run_access("LB",  1, 0, 3'b000, 32'h202, 32'h0, 32'h0080_0000, 0, 0, 0,
                   mk(32'hFFFF_FF80, 1, 0, 3, 32'h200, 0, 4'b0000, 32'h0));
        run_access("LBU", 1, 0, 3'b100, 32'h202, 32'h0, 32'h0080_0000, 0, 0, 0,
                   mk(32'h0000_0080, 1, 0, 3, 32'h200, 0, 4'b0000, 32'h0));
        run_access("LH",  1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 1, 0, 0,
                   mk(32'hFFFF_8001, 1, 0, 4, 32'h100, 0, 4'b0000, 32'h0));
        run_access("LHU", 1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 0, 1, 0,
                   mk(32'h0000_8001, 1, 0, 4, 32'h100, 0, 4'b0000, 32'h0));
        run_access("SH",  0, 1, 3'b001, 32'h102, 32'hFFFF_1234, 32'h0, 0, 0, 0,
                   mk(32'h0, 0, 0, 3, 32'h100, 1, 4'b1100, 32'h1234_1234));
        run_access("SW",  0, 1, 3'b010, 32'h104, 32'hCAFE_F00D, 32'h0, 0, 0, 0,
                   mk(32'h0, 0, 0, 3, 32'h104, 1, 4'b1111, 32'hCAFE_F00D));
        run_access("LWerr", 1, 0, 3'b010, 32'h100, 32'h0, 32'h1234_5678, 2, 2, 1,
                   mk(32'h0, 0, 1, 7, 32'h100, 0, 4'b0000, 32'h0));

        run_reject("LHmis",  1, 0, 3'b001, 32'h101, 1, 0);
        run_reject("LWmis",  1, 0, 3'b010, 32'h102, 1, 0);
        run_reject("SHmis",  0, 1, 3'b001, 32'h103, 1, 0);
        run_reject("LD32",   1, 0, 3'b011, 32'h100, 0, 1);
        run_reject("LWU32",  1, 0, 3'b110, 32'h100, 0, 1);
        run_reject("F3_111", 1, 0, 3'b111, 32'h100, 0, 1);
        run_reject("LDST",   1, 1, 3'b010, 32'h101, 0, 1);

        // Reset while waiting for a response, then a stale response after release
        @(posedge clock); #1;
        mem_load = 1'b1; funct3 = 3'b010; address = 32'h300; bus_if.bus_ready = 1'b1;
        @(negedge clock);
        check("abort idle stall", 64'(stall), 64'(1));
        @(negedge clock);
        check("abort req bus_valid", 64'(bus_if.bus_valid), 64'(1));
        @(posedge clock); #1;
        check("abort rsp stall", 64'(stall), 64'(1));
        reset = 1'b0;
        #1;
        check("abort reset stall",      64'(stall),            64'(0));
        check("abort reset bus_valid",  64'(bus_if.bus_valid), 64'(0));
        check("abort reset load_valid", 64'(load_valid | fault), 64'(0));
        mem_load = 1'b0; bus_if.bus_ready = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
        @(negedge clock);
        check("late rsp load_valid", 64'(load_valid), 64'(0));
        check("late rsp stall",      64'(stall),      64'(0));
        @(posedge clock); #1;
        bus_if.bus_rsp_valid = 1'b0;
        @(negedge clock);
        check("late rsp load_valid next", 64'(load_valid | fault), 64'(0));
        check("late rsp bus_valid",       64'(bus_if.bus_valid),   64'(0));

        run_access("LWrecover", 1, 0, 3'b010, 32'h308, 32'h0, 32'h0BAD_F00D, 0, 0, 0,
                   mk(32'h0BAD_F00D, 1, 0, 3, 32'h308, 0, 4'b0000, 32'h0));
        check("scoreboard empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
